// File: rtl/block_scheduler.sv
// Splits a kernel into fixed-size thread blocks and hands them round-robin to enabled, idle cores.
// Core handshake: core_start[i] stays high with a stable block until a cycle where core_done[i] is also high.
module block_scheduler #(
  parameter int NUM_CORES         = 4,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int TC_WIDTH          = 16,
  parameter int TPB_WIDTH         = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [TC_WIDTH-1:0]            thread_count,
  input  logic [NUM_CORES-1:0]           core_enable,
  input  logic [NUM_CORES-1:0]           core_done,
  output logic [NUM_CORES-1:0]           core_start,
  output logic [NUM_CORES-1:0]           core_reset,
  output logic [NUM_CORES*TC_WIDTH-1:0]  core_block_id,
  output logic [NUM_CORES*TPB_WIDTH-1:0] core_thread_count,
  output logic [TC_WIDTH-1:0]            blocks_done_count,
  output logic                           busy,
  output logic                           done,
  output logic [1:0]                     state_dbg
);

  localparam int LOG2_TPB = $clog2(THREADS_PER_BLOCK);
  localparam int RR_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [TC_WIDTH-1:0]  TPB_MASK = TC_WIDTH'(THREADS_PER_BLOCK - 1);
  localparam logic [TPB_WIDTH-1:0] TPB_FULL = TPB_WIDTH'(THREADS_PER_BLOCK);

  logic [1:0]           state_q, state_d;
  logic [TC_WIDTH-1:0]  tc_q, tc_d;
  logic [TC_WIDTH-1:0]  total_q, total_d;
  logic [TC_WIDTH-1:0]  disp_q, disp_d;
  logic [TC_WIDTH-1:0]  done_cnt_q, done_cnt_d;
  logic [RR_W-1:0]      rr_q, rr_d;
  logic [NUM_CORES-1:0] start_q, start_d;
  logic [NUM_CORES-1:0] crst_q, crst_d;
  logic                 done_flag_q, done_flag_d;
  logic [TC_WIDTH-1:0]  id_q [NUM_CORES];
  logic [TC_WIDTH-1:0]  id_d [NUM_CORES];
  logic [TPB_WIDTH-1:0] thr_q [NUM_CORES];
  logic [TPB_WIDTH-1:0] thr_d [NUM_CORES];

  logic [NUM_CORES-1:0] completions;
  logic [NUM_CORES-1:0] eligible;
  logic [TC_WIDTH-1:0]  comp_count;
  logic [TC_WIDTH:0]    ceil_sum;
  logic [TC_WIDTH-1:0]  total_calc;
  logic [TC_WIDTH-1:0]  tail;
  logic [TPB_WIDTH-1:0] last_thr;
  logic                 sel_found;
  logic [RR_W-1:0]      sel_idx;
  logic [RR_W-1:0]      rr_next;
  int                   cand;

  // Extra top bit keeps thread_count near 2^TC_WIDTH from wrapping in the ceil-divide.
  always_comb begin
    ceil_sum   = {1'b0, thread_count} + (TC_WIDTH + 1)'(THREADS_PER_BLOCK - 1);
    total_calc = TC_WIDTH'(ceil_sum >> LOG2_TPB);
    tail       = tc_q & TPB_MASK;
    last_thr   = (tail == '0) ? TPB_FULL : TPB_WIDTH'(tail);
  end

  // Registered core_start/core_reset give the one-cycle reset gap after a completion.
  assign completions = start_q & core_done;
  assign eligible    = ~start_q & crst_q & core_enable;

  always_comb begin
    comp_count = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      comp_count = comp_count + TC_WIDTH'(completions[i]);
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = (int'(rr_q) + k) % NUM_CORES;
      if (!sel_found && eligible[cand]) begin
        sel_found = 1'b1;
        sel_idx   = RR_W'(cand);
      end
    end
    rr_next = RR_W'((int'(sel_idx) + 1) % NUM_CORES);
  end

  always_comb begin
    state_d     = state_q;
    tc_d        = tc_q;
    total_d     = total_q;
    disp_d      = disp_q;
    done_cnt_d  = done_cnt_q;
    rr_d        = rr_q;
    start_d     = start_q;
    crst_d      = crst_q;
    done_flag_d = done_flag_q;
    id_d        = id_q;
    thr_d       = thr_q;

    case (state_q)
      ST_IDLE: begin
        start_d = '0;
        crst_d  = '1;
        if (start) begin
          tc_d       = thread_count;
          total_d    = total_calc;
          disp_d     = '0;
          done_cnt_d = '0;
          rr_d       = '0;
          if (total_calc != '0) begin
            state_d = ST_RUN;
          end else begin
            state_d     = ST_DONE;
            done_flag_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (!start) begin
          state_d = ST_IDLE;
          start_d = '0;
          crst_d  = '1;
        end else begin
          start_d    = start_q & ~completions;
          crst_d     = crst_q | completions;
          done_cnt_d = done_cnt_q + comp_count;
          if (done_cnt_d == total_q) begin
            state_d     = ST_DONE;
            done_flag_d = 1'b1;
            start_d     = '0;
            crst_d      = '1;
          end else if (sel_found && (disp_q < total_q)) begin
            start_d[sel_idx] = 1'b1;
            crst_d[sel_idx]  = 1'b0;
            id_d[sel_idx]    = disp_q;
            thr_d[sel_idx]   = (disp_q == total_q - TC_WIDTH'(1)) ? last_thr : TPB_FULL;
            disp_d           = disp_q + TC_WIDTH'(1);
            rr_d             = rr_next;
          end
        end
      end

      ST_DONE: begin
        start_d = '0;
        crst_d  = '1;
        if (!start) begin
          state_d     = ST_IDLE;
          done_flag_d = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        start_d     = '0;
        crst_d      = '1;
        done_flag_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      tc_q        <= '0;
      total_q     <= '0;
      disp_q      <= '0;
      done_cnt_q  <= '0;
      rr_q        <= '0;
      start_q     <= '0;
      crst_q      <= '1;
      done_flag_q <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        id_q[i]  <= '0;
        thr_q[i] <= TPB_FULL;
      end
    end else begin
      state_q     <= state_d;
      tc_q        <= tc_d;
      total_q     <= total_d;
      disp_q      <= disp_d;
      done_cnt_q  <= done_cnt_d;
      rr_q        <= rr_d;
      start_q     <= start_d;
      crst_q      <= crst_d;
      done_flag_q <= done_flag_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        id_q[i]  <= id_d[i];
        thr_q[i] <= thr_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_flat
    assign core_block_id[g*TC_WIDTH +: TC_WIDTH]        = id_q[g];
    assign core_thread_count[g*TPB_WIDTH +: TPB_WIDTH] = thr_q[g];
  end

  assign core_start        = start_q;
  assign core_reset        = crst_q;
  assign blocks_done_count = done_cnt_q;
  assign busy              = (state_q == ST_RUN);
  assign done              = done_flag_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_block_scheduler.sv
// Directed bench for block_scheduler: dispatch order, thread counts, completions, enable mask, abort and reset.
module tb_block_scheduler;
  localparam int N    = 4;
  localparam int TCW  = 16;
  localparam int TPBW = 3;

  logic             clk;
  logic             reset;
  logic             start;
  logic [TCW-1:0]   thread_count;
  logic [N-1:0]     core_enable;
  logic [N-1:0]     core_done;
  logic [N-1:0]     core_start;
  logic [N-1:0]     core_reset;
  logic [N*TCW-1:0] core_block_id;
  logic [N*TPBW-1:0] core_thread_count;
  logic [TCW-1:0]   blocks_done_count;
  logic             busy;
  logic             done;
  logic [1:0]       state_dbg;

  int checks   = 0;
  int failures = 0;

  int disp_core[$];
  int disp_id[$];
  int disp_thr[$];
  int gap_viol;
  bit timed_out;

  block_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
    .core_enable(core_enable), .core_done(core_done), .core_start(core_start),
    .core_reset(core_reset), .core_block_id(core_block_id),
    .core_thread_count(core_thread_count), .blocks_done_count(blocks_done_count),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TCW-1:0] get_id(input int i);
    return core_block_id[i*TCW +: TCW];
  endfunction

  function automatic logic [TPBW-1:0] get_thr(input int i);
    return core_thread_count[i*TPBW +: TPBW];
  endfunction

  // Drives one launch and behaves as a core array: each core raises core_done lat[i] samples after it starts.
  task automatic run_kernel(input logic [TCW-1:0] tc, input logic [N-1:0] en,
                            input int l0, input int l1, input int l2, input int l3, input int max_cyc);
    int lat[N];
    int cnt[N];
    logic [N-1:0] prev_start, prev_rst;
    lat = '{l0, l1, l2, l3};
    cnt = '{0, 0, 0, 0};
    disp_core.delete(); disp_id.delete(); disp_thr.delete();
    gap_viol = 0; timed_out = 1'b1;
    core_enable = en; thread_count = tc; core_done = '0; start = 1'b1;
    tick;
    prev_start = core_start; prev_rst = core_reset;
    for (int c = 0; c < max_cyc; c++) begin
      tick;
      core_done = '0;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      for (int i = 0; i < N; i++) begin
        if (core_start[i] && !prev_start[i]) begin
          disp_core.push_back(i); disp_id.push_back(int'(get_id(i))); disp_thr.push_back(int'(get_thr(i)));
          if (!prev_rst[i]) gap_viol++;
          cnt[i] = 0;
        end else if (core_start[i]) begin
          cnt[i]++;
        end
        if (core_start[i] && cnt[i] == lat[i]) core_done[i] = 1'b1;
      end
      prev_start = core_start; prev_rst = core_reset;
    end
    core_done = '0;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; thread_count = '0; core_enable = '1; core_done = '0;
    tick; tick;
    checks++; if (core_start !== 4'h0) begin failures++; $display("FAIL reset_core_start got=%h exp=0", core_start); end
    checks++; if (core_reset !== 4'hF) begin failures++; $display("FAIL reset_core_reset got=%h exp=f", core_reset); end
    for (int i = 0; i < N; i++) begin
      checks++; if (get_id(i) !== 16'd0) begin failures++; $display("FAIL reset_block_id[%0d] got=%0d exp=0", i, get_id(i)); end
      checks++; if (get_thr(i) !== 3'd4) begin failures++; $display("FAIL reset_thr[%0d] got=%0d exp=4", i, get_thr(i)); end
    end
    checks++; if (blocks_done_count !== 16'd0) begin failures++; $display("FAIL reset_blocks_done got=%0d exp=0", blocks_done_count); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    reset = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    core_enable = 4'hF; thread_count = 16'd10; core_done = 4'b1000; start = 1'b1;
    tick;
    checks++; if (busy !== 1'b1 || core_start !== 4'h0) begin failures++; $display("FAIL basic_launch busy=%b start=%h exp busy=1 start=0", busy, core_start); end
    tick;
    checks++; if (core_start !== 4'b0001 || get_id(0) !== 16'd0 || get_thr(0) !== 3'd4) begin failures++; $display("FAIL basic_d0 start=%h id=%0d thr=%0d exp 1/0/4", core_start, get_id(0), get_thr(0)); end
    tick;
    checks++; if (core_start !== 4'b0011 || get_id(1) !== 16'd1 || get_thr(1) !== 3'd4) begin failures++; $display("FAIL basic_d1 start=%h id=%0d thr=%0d exp 3/1/4", core_start, get_id(1), get_thr(1)); end
    tick;
    checks++; if (core_start !== 4'b0111 || get_id(2) !== 16'd2 || get_thr(2) !== 3'd2) begin failures++; $display("FAIL basic_d2 start=%h id=%0d thr=%0d exp 7/2/2", core_start, get_id(2), get_thr(2)); end
    tick;
    checks++; if (core_start !== 4'b0111 || core_reset !== 4'b1000) begin failures++; $display("FAIL basic_hold start=%h rst=%h exp 7/8", core_start, core_reset); end
    checks++; if (blocks_done_count !== 16'd0) begin failures++; $display("FAIL basic_idle_done_ignored got=%0d exp=0", blocks_done_count); end
    core_done = 4'b0111;
    tick;
    core_done = 4'b0000;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || blocks_done_count !== 16'd3) begin failures++; $display("FAIL basic_finish done=%b busy=%b cnt=%0d exp 1/0/3", done, busy, blocks_done_count); end
    checks++; if (core_start !== 4'h0 || core_reset !== 4'hF || state_dbg !== 2'd2) begin failures++; $display("FAIL basic_done_state start=%h rst=%h st=%0d exp 0/f/2", core_start, core_reset, state_dbg); end
    tick;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done_hold got=%b exp=1", done); end
    start = 1'b0;
    tick;
    checks++; if (done !== 1'b0 || state_dbg !== 2'd0) begin failures++; $display("FAIL basic_to_idle done=%b st=%0d exp 0/0", done, state_dbg); end
  endtask

  task automatic test_zero;
    thread_count = 16'd0; start = 1'b1;
    tick;
    checks++; if (done !== 1'b1 || state_dbg !== 2'd2 || core_start !== 4'h0) begin failures++; $display("FAIL zero_launch done=%b st=%0d start=%h exp 1/2/0", done, state_dbg, core_start); end
    tick;
    checks++; if (core_start !== 4'h0 || done !== 1'b1) begin failures++; $display("FAIL zero_hold start=%h done=%b exp 0/1", core_start, done); end
    start = 1'b0;
    tick;
    checks++; if (done !== 1'b0 || state_dbg !== 2'd0) begin failures++; $display("FAIL zero_idle done=%b st=%0d exp 0/0", done, state_dbg); end
  endtask

  task automatic test_staggered;
    int exp_core[8] = '{0, 1, 2, 3, 0, 2, 3, 0};
    run_kernel(16'd32, 4'hF, 3, 7, 2, 5, 60);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL stag_timeout got=%b exp=0", timed_out); end
    checks++; if (disp_core.size() != 8) begin failures++; $display("FAIL stag_count got=%0d exp=8", disp_core.size()); end
    for (int k = 0; k < 8 && k < disp_core.size(); k++) begin
      checks++;
      if (disp_core[k] != exp_core[k] || disp_id[k] != k || disp_thr[k] != 4) begin
        failures++; $display("FAIL stag_dispatch[%0d] core=%0d id=%0d thr=%0d exp %0d/%0d/4", k, disp_core[k], disp_id[k], disp_thr[k], exp_core[k], k);
      end
    end
    checks++; if (gap_viol != 0) begin failures++; $display("FAIL stag_reset_gap got=%0d exp=0", gap_viol); end
    checks++; if (blocks_done_count !== 16'd8 || busy !== 1'b0) begin failures++; $display("FAIL stag_final cnt=%0d busy=%b exp 8/0", blocks_done_count, busy); end
    start = 1'b0;
    tick;
  endtask

  task automatic test_enable_mask;
    int exp_core[4] = '{0, 2, 0, 2};
    run_kernel(16'd16, 4'b0101, 2, 2, 2, 2, 60);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL mask_timeout got=%b exp=0", timed_out); end
    checks++; if (disp_core.size() != 4) begin failures++; $display("FAIL mask_count got=%0d exp=4", disp_core.size()); end
    for (int k = 0; k < 4 && k < disp_core.size(); k++) begin
      checks++;
      if (disp_core[k] != exp_core[k] || disp_id[k] != k) begin
        failures++; $display("FAIL mask_dispatch[%0d] core=%0d id=%0d exp %0d/%0d", k, disp_core[k], disp_id[k], exp_core[k], k);
      end
    end
    checks++; if (blocks_done_count !== 16'd4) begin failures++; $display("FAIL mask_blocks_done got=%0d exp=4", blocks_done_count); end
    start = 1'b0; core_enable = 4'hF;
    tick;
  endtask

  task automatic test_simultaneous;
    core_enable = 4'hF; thread_count = 16'd32; core_done = '0; start = 1'b1;
    tick;
    tick; tick; tick; tick;
    checks++; if (core_start !== 4'hF) begin failures++; $display("FAIL sim_fill got=%h exp=f", core_start); end
    core_done = 4'hF;
    tick;
    core_done = 4'h0;
    checks++; if (blocks_done_count !== 16'd4 || done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL sim_first cnt=%0d done=%b busy=%b exp 4/0/1", blocks_done_count, done, busy); end
    checks++; if (core_start !== 4'h0 || core_reset !== 4'hF) begin failures++; $display("FAIL sim_gap start=%h rst=%h exp 0/f", core_start, core_reset); end
    tick;
    checks++; if (core_start !== 4'b0001 || get_id(0) !== 16'd4) begin failures++; $display("FAIL sim_redispatch start=%h id=%0d exp 1/4", core_start, get_id(0)); end
    tick; tick; tick;
    checks++; if (core_start !== 4'hF || get_id(3) !== 16'd7) begin failures++; $display("FAIL sim_refill start=%h id3=%0d exp f/7", core_start, get_id(3)); end
    core_done = 4'hF;
    tick;
    core_done = 4'h0;
    checks++; if (blocks_done_count !== 16'd8 || done !== 1'b1 || core_reset !== 4'hF) begin failures++; $display("FAIL sim_final cnt=%0d done=%b rst=%h exp 8/1/f", blocks_done_count, done, core_reset); end
    start = 1'b0;
    tick;
  endtask

  task automatic test_relaunch_abort;
    core_enable = 4'hF; thread_count = 16'd5; start = 1'b1;
    tick;
    tick;
    checks++; if (core_start !== 4'b0001 || get_thr(0) !== 3'd4 || get_id(0) !== 16'd0) begin failures++; $display("FAIL relaunch_d0 start=%h id=%0d thr=%0d exp 1/0/4", core_start, get_id(0), get_thr(0)); end
    tick;
    checks++; if (core_start !== 4'b0011 || get_thr(1) !== 3'd1 || get_id(1) !== 16'd1) begin failures++; $display("FAIL relaunch_d1 start=%h id=%0d thr=%0d exp 3/1/1", core_start, get_id(1), get_thr(1)); end
    start = 1'b0;
    tick;
    checks++; if (core_start !== 4'h0 || core_reset !== 4'hF) begin failures++; $display("FAIL abort_cores start=%h rst=%h exp 0/f", core_start, core_reset); end
    checks++; if (done !== 1'b0 || busy !== 1'b0 || state_dbg !== 2'd0) begin failures++; $display("FAIL abort_state done=%b busy=%b st=%0d exp 0/0/0", done, busy, state_dbg); end
    checks++; if (blocks_done_count !== 16'd0) begin failures++; $display("FAIL abort_count got=%0d exp=0", blocks_done_count); end
  endtask

  task automatic test_reset_mid;
    core_enable = 4'hF; thread_count = 16'd32; start = 1'b1;
    tick; tick; tick;
    core_done = 4'b0001;
    tick;
    core_done = 4'b0000;
    checks++; if (blocks_done_count !== 16'd1 || busy !== 1'b1) begin failures++; $display("FAIL rmid_pre cnt=%0d busy=%b exp 1/1", blocks_done_count, busy); end
    reset = 1'b0;
    tick;
    checks++; if (core_start !== 4'h0 || core_reset !== 4'hF || blocks_done_count !== 16'd0) begin failures++; $display("FAIL rmid_outputs start=%h rst=%h cnt=%0d exp 0/f/0", core_start, core_reset, blocks_done_count); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || state_dbg !== 2'd0) begin failures++; $display("FAIL rmid_state busy=%b done=%b st=%0d exp 0/0/0", busy, done, state_dbg); end
    for (int i = 0; i < N; i++) begin
      checks++; if (get_id(i) !== 16'd0 || get_thr(i) !== 3'd4) begin failures++; $display("FAIL rmid_core[%0d] id=%0d thr=%0d exp 0/4", i, get_id(i), get_thr(i)); end
    end
    reset = 1'b1; start = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero;
    test_staggered;
    test_enable_mask;
    test_relaunch_abort;
    test_simultaneous;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
